// File: rtl/intctl_pkg.sv
// -----------------------------------------------------------------------------
// intctl_pkg
// Shared definitions for the interrupt aggregator:
//   - hold_state_e : holdoff FSM state encoding (IDLE / ASSERT / HOLDOFF)
//   - MAX_NUM_SRC  : upper bound on the number of interrupt sources
// -----------------------------------------------------------------------------
package intctl_pkg;

  localparam int MAX_NUM_SRC = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } hold_state_e;

endpackage : intctl_pkg

// File: rtl/irq_holdoff_timer.sv
// -----------------------------------------------------------------------------
// irq_holdoff_timer
// Decides when the CPU interrupt line is asserted. The line follows IntPending
// but, once released, is kept idle for a programmable minimum gap before it can
// assert again.
//
// Ports:
//   Clk           in   system clock, rising edge
//   Reset         in   synchronous, active-high reset
//   IntPending    in   at least one enabled status bit is set
//   HoldoffCycles in   minimum idle gap in Clk cycles (sampled when loaded)
//   Assert        out  1 while the interrupt line should be driven low
// -----------------------------------------------------------------------------
module irq_holdoff_timer
  import intctl_pkg::*;
#(
  parameter int HOLDOFF_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 IntPending,
  input  logic [HOLDOFF_W-1:0] HoldoffCycles,
  output logic                 Assert
);

  hold_state_e          state_q, state_d;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. The gap seen on the pin is one IDLE evaluation cycle plus
  // HoldoffCycles cycles in HOLDOFF, so the counter is loaded with N-1 and the
  // exit happens on the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (IntPending) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (!IntPending) begin
          if (HoldoffCycles != '0) begin
            state_d = ST_HOLDOFF;
            cnt_d   = HoldoffCycles - HOLDOFF_W'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLDOFF: begin
        // Pending events are deliberately ignored here; they are picked up
        // from IDLE once the gap has elapsed.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - HOLDOFF_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign Assert = (state_q == ST_ASSERT);

endmodule : irq_holdoff_timer

// File: rtl/interrupt_aggregator.sv
// -----------------------------------------------------------------------------
// interrupt_aggregator
// Collects NUM_SRC (1..MAX_NUM_SRC) interrupt sources, each either rising-edge
// or level sensitive, into a sticky write-1-to-clear status register, masks
// them with an enable register and drives one open-drain, active-low CPU
// interrupt line with an enforced minimum idle gap between assertions.
//
// Ports:
//   Clk, Reset     in   clock / synchronous active-high reset
//   IntSrc         in   raw source requests (already synchronous to Clk)
//   SrcMode        in   per source: 1 = rising-edge, 0 = level
//   WrEnable       in   strobe: IntEnable <= WrData
//   WrClear        in   strobe: W1C of IntStatus with WrData
//   WrSet          in   strobe: software set of IntStatus bits from WrData
//   WrData         in   CPU write data
//   HoldoffCycles  in   minimum deasserted gap in Clk cycles
//   IntStatus      out  sticky status register
//   IntEnable      out  enable mask register
//   IntPending     out  |(IntStatus & IntEnable)
//   InterruptD     out  open-drain: 0 when asserted, z otherwise
// -----------------------------------------------------------------------------
module interrupt_aggregator
  import intctl_pkg::*;
#(
  parameter int NUM_SRC   = 8,
  parameter int HOLDOFF_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NUM_SRC-1:0]   IntSrc,
  input  logic [NUM_SRC-1:0]   SrcMode,
  input  logic                 WrEnable,
  input  logic                 WrClear,
  input  logic                 WrSet,
  input  logic [NUM_SRC-1:0]   WrData,
  input  logic [HOLDOFF_W-1:0] HoldoffCycles,
  output logic [NUM_SRC-1:0]   IntStatus,
  output logic [NUM_SRC-1:0]   IntEnable,
  output logic                 IntPending,
  output logic                 InterruptD
);

  logic [NUM_SRC-1:0] src_prev_q, src_prev_d;
  logic [NUM_SRC-1:0] status_q, status_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_mask;
  logic               assert_w;

  // Per-source set term: edge or level detection, plus software set.
  // The enable mask is intentionally not applied here, so masked sources are
  // still captured and become visible as soon as they are enabled.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign set_vec[i] = (SrcMode[i] ? (IntSrc[i] & ~src_prev_q[i]) : IntSrc[i])
                      | (WrSet & WrData[i]);
  end

  always_comb begin
    src_prev_d = IntSrc;
    clr_mask   = WrClear ? WrData : '0;
    // Set is ORed after the clear so a coinciding set wins.
    status_d   = (status_q & ~clr_mask) | set_vec;
    enable_d   = WrEnable ? WrData : enable_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      status_q   <= '0;
      enable_q   <= '0;
      // Track the sources through reset so one already high at release is
      // not mistaken for a rising edge.
      src_prev_q <= IntSrc;
    end else begin
      status_q   <= status_d;
      enable_q   <= enable_d;
      src_prev_q <= src_prev_d;
    end
  end

  assign IntStatus  = status_q;
  assign IntEnable  = enable_q;
  assign IntPending = |(status_q & enable_q);

  irq_holdoff_timer #(
    .HOLDOFF_W(HOLDOFF_W)
  ) u_holdoff (
    .Clk          (Clk),
    .Reset        (Reset),
    .IntPending   (IntPending),
    .HoldoffCycles(HoldoffCycles),
    .Assert       (assert_w)
  );

  // Open-drain pin: only ever pulls low; the board pull-up supplies the high.
  assign InterruptD = assert_w ? 1'b0 : 1'bz;

endmodule : interrupt_aggregator

// File: tb/tb_interrupt_aggregator.sv
// -----------------------------------------------------------------------------
// tb_interrupt_aggregator
// Directed bench for interrupt_aggregator (NUM_SRC = 8, HOLDOFF_W = 8).
// The interrupt pin is modelled with a pull-up, so a released line reads 1.
// -----------------------------------------------------------------------------
module tb_interrupt_aggregator;

  localparam int NUM_SRC   = 8;
  localparam int HOLDOFF_W = 8;

  // ---------------------------------------------------------------- clock/reset
  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_SRC-1:0]   int_src;
  logic [NUM_SRC-1:0]   src_mode;
  logic                 wr_enable;
  logic                 wr_clear;
  logic                 wr_set;
  logic [NUM_SRC-1:0]   wr_data;
  logic [HOLDOFF_W-1:0] holdoff_cycles;
  logic [NUM_SRC-1:0]   int_status;
  logic [NUM_SRC-1:0]   int_enable;
  logic                 int_pending;
  wire                  interrupt_d;

  pullup (interrupt_d);

  always #5 clk = ~clk;

  interrupt_aggregator #(
    .NUM_SRC  (NUM_SRC),
    .HOLDOFF_W(HOLDOFF_W)
  ) dut (
    .Clk          (clk),
    .Reset        (reset),
    .IntSrc       (int_src),
    .SrcMode      (src_mode),
    .WrEnable     (wr_enable),
    .WrClear      (wr_clear),
    .WrSet        (wr_set),
    .WrData       (wr_data),
    .HoldoffCycles(holdoff_cycles),
    .IntStatus    (int_status),
    .IntEnable    (int_enable),
    .IntPending   (int_pending),
    .InterruptD   (interrupt_d)
  );

  // ------------------------------------------------------------------ checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------------- drivers
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write_enable(input logic [NUM_SRC-1:0] data);
    wr_enable = 1'b1;
    wr_data   = data;
    tick();
    wr_enable = 1'b0;
    wr_data   = '0;
  endtask

  task automatic cpu_clear(input logic [NUM_SRC-1:0] data);
    wr_clear = 1'b1;
    wr_data  = data;
    tick();
    wr_clear = 1'b0;
    wr_data  = '0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset          = 1'b1;
    int_src        = '0;
    src_mode       = 8'h01;
    wr_enable      = 1'b0;
    wr_clear       = 1'b0;
    wr_set         = 1'b0;
    wr_data        = '0;
    holdoff_cycles = '0;

    tick();
    tick();
    check("reset_status",  32'(int_status), 32'h00);
    check("reset_enable",  32'(int_enable), 32'h00);
    check("reset_pending", 32'(int_pending), 32'h0);
    check("reset_pin",     32'(interrupt_d), 32'h1);
    reset = 1'b0;
    tick();

    // ---- edge mode on source 0
    cpu_write_enable(8'h01);
    check("edge_enable", 32'(int_enable), 32'h01);
    int_src[0] = 1'b1;
    tick();
    check("edge_status_1", 32'(int_status), 32'h01);
    check("edge_pin_1",    32'(interrupt_d), 32'h1);
    tick();
    check("edge_pin_2",    32'(interrupt_d), 32'h0);
    cpu_clear(8'h01);
    check("edge_clr_status", 32'(int_status), 32'h00);
    check("edge_clr_pend",   32'(int_pending), 32'h0);
    check("edge_clr_pin0",   32'(interrupt_d), 32'h0);
    tick();
    check("edge_release",    32'(interrupt_d), 32'h1);
    check("edge_no_reset",   32'(int_status), 32'h00);
    int_src[0] = 1'b0;

    // ---- level mode on source 3
    cpu_write_enable(8'h08);
    int_src[3] = 1'b1;
    tick();
    check("lvl_status", 32'(int_status), 32'h08);
    tick();
    check("lvl_pin", 32'(interrupt_d), 32'h0);
    cpu_clear(8'h08);
    check("lvl_reset_status", 32'(int_status), 32'h08);
    tick();
    check("lvl_pin_held", 32'(interrupt_d), 32'h0);
    int_src[3] = 1'b0;
    tick();
    check("lvl_sticky", 32'(int_status), 32'h08);
    cpu_clear(8'h08);
    check("lvl_clr_status", 32'(int_status), 32'h00);
    tick();
    check("lvl_release", 32'(interrupt_d), 32'h1);

    // ---- masking on source 5 (edge)
    cpu_write_enable(8'h00);
    src_mode = 8'h21;
    int_src[5] = 1'b1;
    tick();
    check("mask_status",  32'(int_status), 32'h20);
    check("mask_pending", 32'(int_pending), 32'h0);
    tick();
    check("mask_pin", 32'(interrupt_d), 32'h1);
    int_src[5] = 1'b0;
    cpu_write_enable(8'h20);
    check("mask_en_pending", 32'(int_pending), 32'h1);
    check("mask_en_pin1",    32'(interrupt_d), 32'h1);
    tick();
    check("mask_en_pin2",    32'(interrupt_d), 32'h0);
    cpu_clear(8'h20);
    tick();
    check("mask_release", 32'(interrupt_d), 32'h1);

    // ---- holdoff gap of 10 cycles, sources 1 and 2 (edge)
    holdoff_cycles = 8'd10;
    src_mode = 8'h27;
    cpu_write_enable(8'h06);
    int_src[1] = 1'b1;
    tick();
    tick();
    check("hold_pin_src1", 32'(interrupt_d), 32'h0);
    cpu_clear(8'h02);
    int_src[2] = 1'b1;
    tick();
    check("hold_status_src2", 32'(int_status), 32'h04);
    // Pin must read released for 11 consecutive samples (this one plus 10).
    check("hold_gap_0", 32'(interrupt_d), 32'h1);
    for (int i = 1; i <= 10; i++) begin
      // Changing the holdoff length mid-holdoff must not alter the current gap.
      if (i == 3) holdoff_cycles = 8'd3;
      tick();
      check($sformatf("hold_gap_%0d", i), 32'(interrupt_d), 32'h1);
    end
    tick();
    check("hold_reassert", 32'(interrupt_d), 32'h0);
    int_src = '0;
    cpu_clear(8'h04);
    holdoff_cycles = '0;
    for (int i = 0; i < 5; i++) tick();
    check("hold_idle_pin", 32'(interrupt_d), 32'h1);

    // ---- set/clear collision on source 0 (edge), then reset during ASSERT
    wr_set  = 1'b1;
    wr_data = 8'h01;
    tick();
    wr_set  = 1'b0;
    wr_data = '0;
    check("sw_set", 32'(int_status), 32'h01);
    int_src[0] = 1'b1;
    cpu_clear(8'h01);
    check("collide_set_wins", 32'(int_status), 32'h01);
    cpu_write_enable(8'h01);
    tick();
    check("rst_pre_pin", 32'(interrupt_d), 32'h0);
    reset = 1'b1;
    tick();
    check("rst_status",  32'(int_status), 32'h00);
    check("rst_enable",  32'(int_enable), 32'h00);
    check("rst_pending", 32'(int_pending), 32'h0);
    check("rst_pin",     32'(interrupt_d), 32'h1);
    reset = 1'b0;
    tick();
    check("rst_no_edge_1", 32'(int_status), 32'h00);
    tick();
    check("rst_no_edge_2", 32'(int_status), 32'h00);
    check("rst_pin_after", 32'(interrupt_d), 32'h1);

    // ------------------------------------------------------------ report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule : tb_interrupt_aggregator
